// File: rtl/exe_div_seq_if.sv
// Handshake/bus bundle between the execute stage and the divide sequencer.
// master: id_exe/ctrl side driving requests; slave: the sequencer.
interface exe_div_seq_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
);
  logic                 start_i;
  logic [1:0]           op_i;
  logic [XLEN-1:0]      op1_i;
  logic [XLEN-1:0]      op2_i;
  logic [REGADDR_W-1:0] reg_waddr_i;
  logic                 flush_i;
  logic                 stall_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 reg_we_o;
  logic [REGADDR_W-1:0] reg_waddr_o;
  logic [XLEN-1:0]      reg_wdata_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    input  stall_o, busy_o, done_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    output stall_o, busy_o, done_o, reg_we_o, reg_waddr_o, reg_wdata_o
  );
endinterface

// File: rtl/exe_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer (radix-2 restoring).
// Magnitudes are divided unsigned; signs are fixed up in a single FIX cycle.
// Divide-by-zero and signed overflow bypass the iteration and finish next cycle.
module exe_div_seq #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5
) (
  input logic         clk_i,
  input logic         rst_i,
  exe_div_seq_if.slave dif
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e               state, state_n;
  logic                 accept, fast, div0, ovf, is_signed;
  logic                 sel_rem, sign1, sign2;
  logic [CW-1:0]        cnt;
  logic [XLEN-1:0]      dvd, dvs, rem;
  logic [REGADDR_W-1:0] waddr_q;
  logic [XLEN:0]        pr, diff;
  logic [XLEN-1:0]      q_fix, r_fix;

  assign is_signed = ~dif.op_i[0];
  assign div0      = (dif.op2_i == '0);
  assign ovf       = is_signed & (dif.op1_i == MIN_NEG) & (dif.op2_i == '1);
  assign fast      = div0 | ovf;

  // Partial remainder keeps the full previous remainder plus the next dividend
  // bit (XLEN+1 bits), so divisors above 2^(XLEN-1) are still handled exactly.
  assign pr    = {rem, dvd[XLEN-1]};
  assign diff  = pr - {1'b0, dvs};
  assign q_fix = (sign1 ^ sign2) ? -dvd : dvd;
  assign r_fix = sign1 ? -rem : rem;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    dif.stall_o = 1'b0;
    dif.done_o  = 1'b0;
    dif.reg_we_o = 1'b0;
    dif.busy_o  = (state != IDLE);
    unique case (state)
      IDLE: if (dif.start_i && !dif.flush_i) begin
        accept      = 1'b1;
        dif.stall_o = rst_i;
        state_n     = fast ? DONE : CALC;
      end
      CALC: begin
        dif.stall_o = 1'b1;
        if (dif.flush_i)     state_n = IDLE;
        else if (cnt == '0)  state_n = FIX;
      end
      FIX: begin
        dif.stall_o = 1'b1;
        state_n     = dif.flush_i ? IDLE : DONE;
      end
      DONE: begin
        dif.done_o   = 1'b1;
        dif.reg_we_o = (dif.reg_waddr_o != '0) & ~dif.flush_i;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, restoring iteration and result/writeback registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sel_rem         <= 1'b0;
      sign1           <= 1'b0;
      sign2           <= 1'b0;
      cnt             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      rem             <= '0;
      waddr_q         <= '0;
      dif.reg_waddr_o <= '0;
      dif.reg_wdata_o <= '0;
    end else begin
      if (accept) begin
        sel_rem <= dif.op_i[1];
        sign1   <= is_signed & dif.op1_i[XLEN-1];
        sign2   <= is_signed & dif.op2_i[XLEN-1];
        dvd     <= (is_signed & dif.op1_i[XLEN-1]) ? -dif.op1_i : dif.op1_i;
        dvs     <= (is_signed & dif.op2_i[XLEN-1]) ? -dif.op2_i : dif.op2_i;
        rem     <= '0;
        cnt     <= CW'(XLEN-1);
        waddr_q <= dif.reg_waddr_i;
        if (fast) begin
          dif.reg_waddr_o <= dif.reg_waddr_i;
          if (div0) dif.reg_wdata_o <= dif.op_i[1] ? dif.op1_i : '1;
          else      dif.reg_wdata_o <= dif.op_i[1] ? '0 : MIN_NEG;
        end
      end
      if (state == CALC && !dif.flush_i) begin
        // Quotient bits shift into the vacated low end of the dividend.
        rem <= diff[XLEN] ? pr[XLEN-1:0] : diff[XLEN-1:0];
        dvd <= {dvd[XLEN-2:0], ~diff[XLEN]};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX && !dif.flush_i) begin
        dif.reg_wdata_o <= sel_rem ? r_fix : q_fix;
        dif.reg_waddr_o <= waddr_q;
      end
    end
  end
endmodule

// File: tb/tb_exe_div_seq.sv
// Directed bench for exe_div_seq: stimulus pushes expected writebacks into a
// scoreboard; a negedge monitor pops and compares on every done_o.
module tb_exe_div_seq;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int LAT  = XLEN + 2;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;

  typedef struct {
    logic [XLEN-1:0] data;
    logic            we;
    logic [RW-1:0]   wa;
    int              dc;
  } exp_t;
  exp_t sb[$];

  exe_div_seq_if #(.XLEN(XLEN), .REGADDR_W(RW)) dif ();

  exe_div_seq #(.XLEN(XLEN), .REGADDR_W(RW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .dif   (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [RW-1:0] wa);
    dif.start_i     = 1'b1;
    dif.op_i        = op;
    dif.op1_i       = a;
    dif.op2_i       = b;
    dif.reg_waddr_i = wa;
  endtask

  task automatic expect_wb(input logic [XLEN-1:0] d, input logic we, input logic [RW-1:0] wa, input int dc);
    exp_t e;
    e.data = d; e.we = we; e.wa = wa; e.dc = dc;
    sb.push_back(e);
  endtask

  // Issue in the current cycle and wait until one cycle past the expected done.
  task automatic run(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                     input logic [RW-1:0] wa, input logic [XLEN-1:0] exp, input bit fast);
    int dc;
    dc = cyc + (fast ? 1 : LAT);
    expect_wb(exp, wa != '0, wa, dc);
    drive(op, a, b, wa);
    tick();
    dif.start_i = 1'b0;
    while (cyc <= dc) tick();
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_i && dif.done_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.dc));
        chk("wdata", dif.reg_wdata_o, e.data);
        chk("we", 32'(dif.reg_we_o), 32'(e.we));
        chk("waddr", 32'(dif.reg_waddr_o), 32'(e.wa));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    dif.start_i = 1'b0; dif.op_i = '0; dif.op1_i = '0; dif.op2_i = '0;
    dif.reg_waddr_i = '0; dif.flush_i = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(dif.busy_o), 0);
    chk("rst_done", 32'(dif.done_o), 0);
    chk("rst_wdata", dif.reg_wdata_o, 0);
    chk("rst_waddr", 32'(dif.reg_waddr_o), 0);
    rst_i = 1'b1;
    tick();

    // DIVU 100/7 with stall profile over every cycle.
    base = cyc;
    expect_wb(32'd14, 1'b1, 5'd1, base + LAT);
    drive(2'b01, 32'd100, 32'd7, 5'd1);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      chk("stall_profile", 32'(dif.stall_o), 32'(i <= LAT - 1));
      tick();
      dif.start_i = 1'b0;
    end
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();

    run(2'b11, 32'd100, 32'd7, 5'd2, 32'd2, 1'b0);
    run(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0);
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFF, 1'b0);
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd4, 32'hFFFF_FFFD, 1'b0);
    run(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 5'd5, 32'd1, 1'b0);
    run(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 5'd5, 32'h7FFF_FFFE, 1'b0);
    run(2'b01, 32'h1234_5678, 32'd0, 5'd6, 32'hFFFF_FFFF, 1'b1);
    run(2'b11, 32'h1234_5678, 32'd0, 5'd6, 32'h1234_5678, 1'b1);
    run(2'b01, 32'h1234_5678, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1'b1);

    // Flush while in DONE: pulse still appears but writeback is suppressed.
    expect_wb(32'hFFFF_FFFF, 1'b0, 5'd9, cyc + 1);
    drive(2'b01, 32'd5, 32'd0, 5'd9);
    tick();
    dif.start_i = 1'b0;
    dif.flush_i = 1'b1;
    tick();
    dif.flush_i = 1'b0;
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();

    // Flush in cycle 10, restart in cycle 11.
    base = cyc;
    drive(2'b01, 32'd1000, 32'd3, 5'd10);
    tick();
    dif.start_i = 1'b0;
    while (cyc < base + 10) tick();
    dif.flush_i = 1'b1;
    tick();
    dif.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(dif.busy_o), 0);
    chk("flush_stall", 32'(dif.stall_o), 0);
    chk("flush_cycle", 32'(cyc - base), 32'd11);
    run(2'b01, 32'd1000, 32'd3, 5'd11, 32'd333, 1'b0);

    // Asynchronous reset mid-operation.
    base = cyc;
    drive(2'b01, 32'd100, 32'd7, 5'd12);
    tick();
    dif.start_i = 1'b0;
    while (cyc < base + 20) tick();
    #1 rst_i = 1'b0;
    #1;
    chk("arst_stall", 32'(dif.stall_o), 0);
    chk("arst_busy", 32'(dif.busy_o), 0);
    chk("arst_done", 32'(dif.done_o), 0);
    chk("arst_we", 32'(dif.reg_we_o), 0);
    chk("arst_waddr", 32'(dif.reg_waddr_o), 0);
    chk("arst_wdata", dif.reg_wdata_o, 0);
    tick(); tick();
    rst_i = 1'b1;
    repeat (LAT + 4) tick();

    // Starts while busy (cycle 5) and in DONE (cycle 34) are ignored.
    base = cyc;
    expect_wb(32'd14, 1'b1, 5'd13, base + LAT);
    drive(2'b01, 32'd100, 32'd7, 5'd13);
    tick();
    dif.start_i = 1'b0;
    while (cyc < base + 5) tick();
    drive(2'b01, 32'd50, 32'd5, 5'd14);
    tick();
    dif.start_i = 1'b0;
    while (cyc < base + LAT) tick();
    drive(2'b01, 32'd50, 32'd5, 5'd14);
    tick();
    dif.start_i = 1'b0;
    chk("ign_done_seen", 32'(sb.size()), 32'd0);
    run(2'b11, 32'd100, 32'd7, 5'd15, 32'd2, 1'b0);
    chk("ign_final_cycle", 32'(cyc - base), 32'(2 * LAT + 2));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
